// File: rtl/tar_alu_pkg.sv
// Shared types and widths for the ALU scheduler and any other block that
// drives the shared ALU.
package tar_alu_pkg;

    localparam int ALU_W = 32;
    localparam int OP_W  = 3;

    typedef logic [OP_W-1:0] opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } sched_state_e;

endpackage

// File: rtl/tar_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// wrapping around, as both a one-hot vector and an index.
module tar_rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/tar_alu_scheduler.sv
// Shares one ALU among NUM_REQ requesters: round-robin grant, operands held for
// the ALU latency, then the captured result returned on a valid/ready response.
module tar_alu_scheduler
    import tar_alu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int ALU_LAT = 1,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*ALU_W-1:0] req_a,
    input  logic [NUM_REQ*ALU_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]  req_op,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [ALU_W-1:0]         rsp_result,
    output logic                     rsp_error,
    output logic signed [ALU_W-1:0]  alu_a,
    output logic [ALU_W-1:0]         alu_b,
    output logic [OP_W-1:0]          alu_op,
    input  logic [ALU_W-1:0]         alu_result,
    input  logic                     alu_error,
    output logic                     busy,
    output logic [IW-1:0]            grant_id
);

    localparam int CW = 3;

    sched_state_e     state_q, state_d;
    logic [ALU_W-1:0] alu_a_q, alu_a_d;
    logic [ALU_W-1:0] alu_b_q, alu_b_d;
    opcode_t          alu_op_q, alu_op_d;
    logic [ALU_W-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_error_q, rsp_error_d;
    logic [IW-1:0]    grant_id_q, grant_id_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    lat_cnt_q, lat_cnt_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;

    tar_rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        grant_id_d   = grant_id_q;
        rr_ptr_d     = rr_ptr_q;
        lat_cnt_d    = lat_cnt_q;
        req_ready    = '0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready  = arb_grant;
                    alu_a_d    = req_a[int'(arb_idx)*ALU_W +: ALU_W];
                    alu_b_d    = req_b[int'(arb_idx)*ALU_W +: ALU_W];
                    alu_op_d   = req_op[int'(arb_idx)*OP_W +: OP_W];
                    grant_id_d = arb_idx;
                    lat_cnt_d  = '0;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                // One extra cycle beyond ALU_LAT so the result is sampled after it settles.
                if (lat_cnt_q == CW'(ALU_LAT)) begin
                    rsp_result_d = alu_result;
                    rsp_error_d  = alu_error;
                    state_d      = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready[grant_id_q]) begin
                    rr_ptr_d = (grant_id_q == IW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[grant_id_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
            grant_id_q   <= '0;
            rr_ptr_q     <= '0;
            lat_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
            grant_id_q   <= grant_id_d;
            rr_ptr_q     <= rr_ptr_d;
            lat_cnt_q    <= lat_cnt_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_result = rsp_result_q;
    assign rsp_error  = rsp_error_q;
    assign grant_id   = grant_id_q;
    assign busy       = (state_q != IDLE);

endmodule
